// File: rtl/cpu_pkg.sv
// Shared CPU definitions: zero-register index, register index type and
// operand-forwarding source selector.
package cpu_pkg;

    localparam logic [4:0] REG_ZR = 5'd31;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [2:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX,
        FWD_ZERO
    } fwd_sel_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand source resolver: compares one source register against the
// EX/MEM/WB write tuples and picks the operand value.
// Build option OPERAND_STAGE_FWD_EN: when defined, results are bypassed from
// EX > MEM > WB and only a load in EX raises the hazard flag; when undefined,
// operands come from the register file and any pending write to the source
// raises the hazard flag.
module operand_fwd_mux
    import cpu_pkg::*;
(
    input  reg_idx_t    src_i,
    input  logic        ex_valid_i,
    input  logic        ex_wen_i,
    input  logic        ex_is_load_i,
    input  reg_idx_t    ex_wsel_i,
    input  logic [31:0] ex_result_i,
    input  logic        mem_valid_i,
    input  logic        mem_wen_i,
    input  reg_idx_t    mem_wsel_i,
    input  logic [31:0] mem_result_i,
    input  logic        wb_valid_i,
    input  logic        wb_wen_i,
    input  reg_idx_t    wb_wsel_i,
    input  logic [31:0] wb_result_i,
    input  logic [31:0] rf_data_i,
    output fwd_sel_t    sel_o,
    output logic [31:0] value_o,
    output logic        load_hazard_o
);

    logic is_zr;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // Producer matches; r31 is hardwired zero and never matches a producer
    always_comb begin
        is_zr   = (src_i == REG_ZR);
        ex_hit  = ex_valid_i  & ex_wen_i  & (src_i == ex_wsel_i)  & ~is_zr;
        mem_hit = mem_valid_i & mem_wen_i & (src_i == mem_wsel_i) & ~is_zr;
        wb_hit  = wb_valid_i  & wb_wen_i  & (src_i == wb_wsel_i)  & ~is_zr;
    end

`ifdef OPERAND_STAGE_FWD_EN
    // Youngest producer wins; WB must be bypassed because the register file
    // write lands on the same edge this read is captured
    always_comb begin
        sel_o   = FWD_RF;
        value_o = rf_data_i;
        if (is_zr) begin
            sel_o   = FWD_ZERO;
            value_o = 32'h0;
        end else if (ex_hit) begin
            sel_o   = FWD_EX;
            value_o = ex_result_i;
        end else if (mem_hit) begin
            sel_o   = FWD_MEM;
            value_o = mem_result_i;
        end else if (wb_hit) begin
            sel_o   = FWD_WB;
            value_o = wb_result_i;
        end
    end

    // A load in EX has no data yet; it forwards from MEM one cycle later
    assign load_hazard_o = ex_hit & ex_is_load_i;
`else
    // No bypass: only the register file (or the zero register) feeds operands
    always_comb begin
        sel_o   = FWD_RF;
        value_o = rf_data_i;
        if (is_zr) begin
            sel_o   = FWD_ZERO;
            value_o = 32'h0;
        end
    end

    // Any in-flight write to this source must retire before the read
    assign load_hazard_o = ex_hit | mem_hit | wb_hit;

    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load_i, ex_result_i, mem_result_i, wb_result_i};
`endif

endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: drives register-file read selects, resolves
// RAW hazards (bypass or interlock), and holds the ID/EX register behind a
// valid/ready handshake.
// Build option OPERAND_STAGE_FWD_EN selects full forwarding (load-use stall
// only); undefined builds interlock on every pending write.
module operand_stage
    import cpu_pkg::*;
#(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rsel1,
    input  logic [4:0]        in_rsel2,
    input  logic [4:0]        in_wsel,
    input  logic              in_wen,
    input  logic              in_is_load,
    input  logic              in_use_imm,
    input  logic [31:0]       in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_rsel1,
    output logic [4:0]        rf_rsel2,
    input  logic [31:0]       rf_read1,
    input  logic [31:0]       rf_read2,
    input  logic              ex_valid,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_wsel,
    input  logic [31:0]       ex_result,
    input  logic              mem_valid,
    input  logic              mem_wen,
    input  logic [4:0]        mem_wsel,
    input  logic [31:0]       mem_result,
    input  logic              wb_valid,
    input  logic              wb_wen,
    input  logic [4:0]        wb_wsel,
    input  logic [31:0]       wb_result,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_op1,
    output logic [31:0]       out_op2,
    output logic [4:0]        out_wsel,
    output logic              out_wen,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl
);

    fwd_sel_t    sel_a, sel_b;
    logic [31:0] val_a, val_b;
    logic        hz_a, hz_b;
    logic        stall;
    logic        accept;
    logic [31:0] op2_d;

    logic              valid_q;
    logic [31:0]       op1_q, op2_q;
    logic [4:0]        wsel_q;
    logic              wen_q, ld_q;
    logic [CTRL_W-1:0] ctrl_q;

    assign rf_rsel1 = in_rsel1;
    assign rf_rsel2 = in_rsel2;

    operand_fwd_mux u_fwd_a (
        .src_i        (in_rsel1),
        .ex_valid_i   (ex_valid),
        .ex_wen_i     (ex_wen),
        .ex_is_load_i (ex_is_load),
        .ex_wsel_i    (ex_wsel),
        .ex_result_i  (ex_result),
        .mem_valid_i  (mem_valid),
        .mem_wen_i    (mem_wen),
        .mem_wsel_i   (mem_wsel),
        .mem_result_i (mem_result),
        .wb_valid_i   (wb_valid),
        .wb_wen_i     (wb_wen),
        .wb_wsel_i    (wb_wsel),
        .wb_result_i  (wb_result),
        .rf_data_i    (rf_read1),
        .sel_o        (sel_a),
        .value_o      (val_a),
        .load_hazard_o(hz_a)
    );

    operand_fwd_mux u_fwd_b (
        .src_i        (in_rsel2),
        .ex_valid_i   (ex_valid),
        .ex_wen_i     (ex_wen),
        .ex_is_load_i (ex_is_load),
        .ex_wsel_i    (ex_wsel),
        .ex_result_i  (ex_result),
        .mem_valid_i  (mem_valid),
        .mem_wen_i    (mem_wen),
        .mem_wsel_i   (mem_wsel),
        .mem_result_i (mem_result),
        .wb_valid_i   (wb_valid),
        .wb_wen_i     (wb_wen),
        .wb_wsel_i    (wb_wsel),
        .wb_result_i  (wb_result),
        .rf_data_i    (rf_read2),
        .sel_o        (sel_b),
        .value_o      (val_b),
        .load_hazard_o(hz_b)
    );

    // Selector codes are for debug visibility only
    logic unused_sel;
    assign unused_sel = ^{sel_a, sel_b};

    // Interlock and handshake; operand B hazards are ignored for immediates
    always_comb begin
        stall    = in_valid & (hz_a | (hz_b & ~in_use_imm));
        in_ready = ~stall & (out_ready | ~valid_q);
        accept   = in_valid & in_ready;
        op2_d    = in_use_imm ? in_imm : val_b;
    end

    // ID/EX register: load on accept, hold under backpressure, bubble when
    // drained with nothing new; flush kills whatever would be live next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            wsel_q  <= '0;
            wen_q   <= 1'b0;
            ld_q    <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            if (accept) begin
                op1_q  <= val_a;
                op2_q  <= op2_d;
                wsel_q <= in_wsel;
                wen_q  <= in_wen;
                ld_q   <= in_is_load;
                ctrl_q <= in_ctrl;
            end
            if (flush)          valid_q <= 1'b0;
            else if (accept)    valid_q <= 1'b1;
            else if (out_ready) valid_q <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign out_op1     = op1_q;
    assign out_op2     = op2_q;
    assign out_wsel    = wsel_q;
    assign out_wen     = wen_q;
    assign out_is_load = ld_q;
    assign out_ctrl    = ctrl_q;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed hazard scenarios followed by
// randomized traffic, compared against a behavioural model that owns the
// register file contents. Expectations follow OPERAND_STAGE_FWD_EN if defined.
module tb_operand_stage;

    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [4:0]        in_rsel1, in_rsel2, in_wsel;
    logic              in_wen, in_is_load, in_use_imm;
    logic [31:0]       in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        rf_rsel1, rf_rsel2;
    logic [31:0]       rf_read1, rf_read2;
    logic              ex_valid, ex_wen, ex_is_load;
    logic [4:0]        ex_wsel;
    logic [31:0]       ex_result;
    logic              mem_valid, mem_wen;
    logic [4:0]        mem_wsel;
    logic [31:0]       mem_result;
    logic              wb_valid, wb_wen;
    logic [4:0]        wb_wsel;
    logic [31:0]       wb_result;
    logic              flush;
    logic              out_valid, out_ready;
    logic [31:0]       out_op1, out_op2;
    logic [4:0]        out_wsel;
    logic              out_wen, out_is_load;
    logic [CTRL_W-1:0] out_ctrl;

    always #5 clk = ~clk;

    // Register file owned by the bench; reads are combinational
    logic [31:0] regs [32];
    assign rf_read1 = regs[rf_rsel1];
    assign rf_read2 = regs[rf_rsel2];

    operand_stage #(.CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rsel1(in_rsel1), .in_rsel2(in_rsel2), .in_wsel(in_wsel),
        .in_wen(in_wen), .in_is_load(in_is_load), .in_use_imm(in_use_imm),
        .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2),
        .rf_read1(rf_read1), .rf_read2(rf_read2),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .ex_wsel(ex_wsel), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_wsel(mem_wsel),
        .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_wsel(wb_wsel),
        .wb_result(wb_result),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_wsel(out_wsel),
        .out_wen(out_wen), .out_is_load(out_is_load), .out_ctrl(out_ctrl)
    );

    int checks = 0;
    int errors = 0;

    // Model of the ID/EX contents
    logic              m_valid;
    logic [31:0]       m_op1, m_op2;
    logic [4:0]        m_wsel;
    logic              m_wen, m_ld;
    logic [CTRL_W-1:0] m_ctrl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Operand value and hazard for one source, from the pipeline's pending writes
    function automatic void lookup(input logic [4:0] src, output logic [31:0] val,
                                   output logic hz);
        logic [4:0]  ws [3];
        logic        live [3];
        logic [31:0] res [3];
        ws   = '{ex_wsel, mem_wsel, wb_wsel};
        live = '{ex_valid & ex_wen, mem_valid & mem_wen, wb_valid & wb_wen};
        res  = '{ex_result, mem_result, wb_result};
        val  = regs[src];
        hz   = 1'b0;
        if (src == 5'd31) begin
            val = 32'h0;
            return;
        end
`ifdef OPERAND_STAGE_FWD_EN
        // oldest first so the youngest producer overwrites
        for (int s = 2; s >= 0; s--)
            if (live[s] && ws[s] == src) val = res[s];
        hz = live[0] && ws[0] == src && ex_is_load;
`else
        for (int s = 0; s < 3; s++)
            if (live[s] && ws[s] == src) hz = 1'b1;
`endif
    endfunction

    task automatic chk_outs();
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_op1", out_op1, m_op1);
            chk("out_op2", out_op2, m_op2);
            chk("out_wsel", out_wsel, m_wsel);
            chk("out_wen", out_wen, m_wen);
            chk("out_is_load", out_is_load, m_ld);
            chk("out_ctrl", out_ctrl, m_ctrl);
        end
    endtask

    task automatic chk_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_op1", out_op1, 0);
        chk("rst_op2", out_op2, 0);
        chk("rst_wsel", out_wsel, 0);
        chk("rst_wen", out_wen, 0);
        chk("rst_is_load", out_is_load, 0);
        chk("rst_ctrl", out_ctrl, 0);
    endtask

    // One clock: check in_ready before the edge, outputs after it
    task automatic step();
        logic [31:0] a, b;
        logic        ha, hb, stall, rdy, acc;
        #1;
        lookup(in_rsel1, a, ha);
        lookup(in_rsel2, b, hb);
        stall = in_valid && (ha || (hb && !in_use_imm));
        rdy   = !stall && (out_ready || !m_valid);
        acc   = in_valid && rdy;
        chk("in_ready", in_ready, rdy);
        chk("rf_rsel1", rf_rsel1, in_rsel1);
        chk("rf_rsel2", rf_rsel2, in_rsel2);
        @(posedge clk);
        if (wb_valid && wb_wen) regs[wb_wsel] = wb_result;
        if (acc) begin
            m_op1  = a;
            m_op2  = in_use_imm ? in_imm : b;
            m_wsel = in_wsel;
            m_wen  = in_wen;
            m_ld   = in_is_load;
            m_ctrl = in_ctrl;
        end
        if (flush)          m_valid = 1'b0;
        else if (acc)       m_valid = 1'b1;
        else if (out_ready) m_valid = 1'b0;
        #1;
        chk_outs();
    endtask

    task automatic idle();
        in_valid = 0; in_rsel1 = 0; in_rsel2 = 0; in_wsel = 0; in_wen = 0;
        in_is_load = 0; in_use_imm = 0; in_imm = 0; in_ctrl = 0;
        ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_wsel = 0; ex_result = 0;
        mem_valid = 0; mem_wen = 0; mem_wsel = 0; mem_result = 0;
        wb_valid = 0; wb_wen = 0; wb_wsel = 0; wb_result = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic model_reset();
        m_valid = 0; m_op1 = 0; m_op2 = 0; m_wsel = 0; m_wen = 0; m_ld = 0; m_ctrl = 0;
    endtask

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 9) == 9) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        idle();
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst = 0;

        // all stages write r3; the youngest (EX) must win when bypassing
        regs[3] = 32'h44;
        in_valid = 1; in_rsel1 = 3; in_rsel2 = 3; in_wsel = 4; in_wen = 1; in_ctrl = 8'h5A;
        ex_valid = 1; ex_wen = 1; ex_wsel = 3; ex_result = 32'h11;
        mem_valid = 1; mem_wen = 1; mem_wsel = 3; mem_result = 32'h22;
        wb_valid = 1; wb_wen = 1; wb_wsel = 3; wb_result = 32'h33;
        step();
`ifdef OPERAND_STAGE_FWD_EN
        chk("s2_op1_ex", out_op1, 32'h11);
        chk("s2_op2_ex", out_op2, 32'h11);
`else
        chk("s2_stalled", out_valid, 0);
`endif
        ex_valid = 0;  step();
        mem_valid = 0; step();
        wb_valid = 0;  step();
        chk("s2_final_op1", out_op1, 32'h33);

        // load-use on r5 then MEM forwarding of the loaded value
        idle();
        in_valid = 1; in_rsel1 = 5; in_rsel2 = 1; in_wsel = 6; in_wen = 1;
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_wsel = 5; ex_result = 32'hBAD;
        step();
        chk("s3_bubble", out_valid, 0);
        ex_valid = 0; ex_is_load = 0;
        mem_valid = 1; mem_wen = 1; mem_wsel = 5; mem_result = 32'hABCD;
        step();
        mem_valid = 0;
        wb_valid = 1; wb_wen = 1; wb_wsel = 5; wb_result = 32'hABCD;
        step();
        wb_valid = 0;
        step();
        chk("s3_final_op1", out_op1, 32'hABCD);

        // WB write races the register-file read of r7
        idle();
        regs[7] = 32'h0;
        in_valid = 1; in_rsel1 = 2; in_rsel2 = 7; in_wsel = 8;
        wb_valid = 1; wb_wen = 1; wb_wsel = 7; wb_result = 32'hDEAD;
        step();
        wb_valid = 0;
        step();
        chk("s4_op2_wb", out_op2, 32'hDEAD);

        // r31 reads zero and is never a hazard; immediate masks operand B
        idle();
        in_valid = 1; in_rsel1 = 31; in_rsel2 = 9; in_use_imm = 1; in_imm = 32'hCAFE_F00D;
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_wsel = 31; ex_result = 32'hFFFF;
        mem_valid = 1; mem_wen = 1; mem_wsel = 9; mem_result = 32'h9;
        step();
        chk("s5_op1_zero", out_op1, 32'h0);
        chk("s5_op2_imm", out_op2, 32'hCAFE_F00D);
        chk("s5_no_stall", out_valid, 1);

        // backpressure hold, then flush
        idle();
        in_valid = 1; in_rsel1 = 1; in_rsel2 = 2; in_wsel = 3; in_ctrl = 8'hC3;
        step();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_rsel1 = 5'(4 + i); in_ctrl = 8'(i);
            step();
        end
        chk("s6_ctrl_held", out_ctrl, 8'hC3);
        flush = 1;
        step();
        chk("s6_flushed", out_valid, 0);
        flush = 0;

        // reset in the middle of a live instruction
        idle();
        in_valid = 1; in_rsel1 = 1; in_rsel2 = 2; in_wsel = 5; in_wen = 1; in_ctrl = 8'hEE;
        step();
        #2 rst = 1;
        #1 chk_reset();
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        in_valid = 0;
        step();
        in_valid = 1;
        step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_rsel1   = rnd_reg();
            in_rsel2   = rnd_reg();
            in_wsel    = rnd_reg();
            in_wen     = 1'($urandom);
            in_is_load = ($urandom_range(0, 3) == 0);
            in_use_imm = ($urandom_range(0, 3) == 0);
            in_imm     = $urandom;
            in_ctrl    = 8'($urandom);
            ex_valid   = 1'($urandom); ex_wen = 1'($urandom);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_wsel    = rnd_reg(); ex_result = $urandom;
            mem_valid  = 1'($urandom); mem_wen = 1'($urandom);
            mem_wsel   = rnd_reg(); mem_result = $urandom;
            wb_valid   = 1'($urandom); wb_wen = 1'($urandom);
            wb_wsel    = rnd_reg(); wb_result = $urandom;
            flush      = ($urandom_range(0, 15) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
